// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, skid state and entry layout for pipe_stage.
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_SIDE_W = 32;
  localparam int PIPE_PC_W   = 32;
  typedef enum logic {SKID_EMPTY = 1'b0, SKID_FULL = 1'b1} skid_state_e;
  typedef struct packed {
    logic                   valid;
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_SIDE_W-1:0] side;
    logic [PIPE_PC_W-1:0]   pc;
    logic                   is_bds;
    logic                   is_flushed;
  } pipe_entry_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one loadable pipeline entry; kill turns the loaded or held entry into a flushed bubble.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = PIPE_DATA_W,
  parameter int                SIDE_W  = PIPE_SIDE_W,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic              kill,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  input  logic [31:0]       in_pc,
  input  logic              in_is_bds,
  input  logic              in_is_flushed,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [SIDE_W-1:0] q_side,
  output logic [31:0]       q_pc,
  output logic              q_is_bds,
  output logic              q_is_flushed
);
  logic              valid_q, valid_d, bds_q, bds_d, flushed_q, flushed_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [31:0]       pc_q, pc_d;
  always_comb begin
    valid_d   = load ? (in_valid & ~kill) : (valid_q & ~kill);
    data_d    = load ? ((in_valid & ~kill) ? in_data : NOP_VAL) : (kill ? NOP_VAL : data_q);
    side_d    = load ? in_side : side_q;
    pc_d      = load ? in_pc : pc_q;
    bds_d     = load ? in_is_bds : bds_q;
    flushed_d = kill | (load ? in_is_flushed : flushed_q);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q   <= 1'b0;
      data_q    <= NOP_VAL;
      side_q    <= '0;
      pc_q      <= '0;
      bds_q     <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      side_q    <= side_d;
      pc_q      <= pc_d;
      bds_q     <= bds_d;
      flushed_q <= flushed_d;
    end
  end
  assign q_valid      = valid_q;
  assign q_data       = data_q;
  assign q_side       = side_q;
  assign q_pc         = pc_q;
  assign q_is_bds     = bds_q;
  assign q_is_flushed = flushed_q;
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: registered pipeline stage with flush, stall and restart-PC tracking.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = PIPE_DATA_W,
  parameter int                SIDE_W  = PIPE_SIDE_W,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  input  logic [31:0]       in_pc,
  input  logic              in_is_bds,
  input  logic              flush,
  input  logic              out_stall,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SIDE_W-1:0] out_side,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_restart_pc,
  output logic              out_is_bds,
  output logic              out_is_flushed
);
  logic              main_load, main_kill;
  logic              src_valid, src_is_bds, src_is_flushed;
  logic [DATA_W-1:0] src_data;
  logic [SIDE_W-1:0] src_side;
  logic [31:0]       src_pc, restart_q, restart_d;
`ifdef PIPE_STAGE_SKID_EN
  skid_state_e       state_q, state_d;
  logic              skid_load, skid_kill, sk_valid, sk_is_bds, sk_is_flushed;
  logic [DATA_W-1:0] sk_data;
  logic [SIDE_W-1:0] sk_side;
  logic [31:0]       sk_pc;
  // While FULL the main entry refills from skid only; upstream is held off by in_ready.
  always_comb begin
    skid_load      = (state_q == SKID_EMPTY) & out_stall & in_valid;
    skid_kill      = flush & (skid_load | (state_q == SKID_FULL));
    state_d        = out_stall ? (skid_load ? SKID_FULL : state_q) : SKID_EMPTY;
    main_load      = ~out_stall;
    main_kill      = flush & ~out_stall;
    src_valid      = (state_q == SKID_FULL) ? sk_valid : in_valid;
    src_data       = (state_q == SKID_FULL) ? sk_data : in_data;
    src_side       = (state_q == SKID_FULL) ? sk_side : in_side;
    src_pc         = (state_q == SKID_FULL) ? sk_pc : in_pc;
    src_is_bds     = (state_q == SKID_FULL) ? sk_is_bds : in_is_bds;
    src_is_flushed = (state_q == SKID_FULL) ? sk_is_flushed : 1'b0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= SKID_EMPTY;
    else        state_q <= state_d;
  end
  assign in_ready = (state_q == SKID_EMPTY);
  pipe_entry_reg #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .NOP_VAL(NOP_VAL)) u_skid (
    .CLK(CLK), .RST_N(RST_N), .load(skid_load), .kill(skid_kill),
    .in_valid(in_valid), .in_data(in_data), .in_side(in_side), .in_pc(in_pc),
    .in_is_bds(in_is_bds), .in_is_flushed(1'b0),
    .q_valid(sk_valid), .q_data(sk_data), .q_side(sk_side), .q_pc(sk_pc),
    .q_is_bds(sk_is_bds), .q_is_flushed(sk_is_flushed)
  );
`else
  always_comb begin
    main_load      = ~out_stall;
    main_kill      = flush & ~out_stall;
    src_valid      = in_valid;
    src_data       = in_data;
    src_side       = in_side;
    src_pc         = in_pc;
    src_is_bds     = in_is_bds;
    src_is_flushed = 1'b0;
  end
  assign in_ready = ~out_stall;
`endif
  // A delay slot keeps its branch's PC so an exception restarts at the branch.
  always_comb restart_d = (main_load & ~main_kill & ~src_is_bds & ~src_is_flushed) ? src_pc : restart_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) restart_q <= '0;
    else        restart_q <= restart_d;
  end
  assign out_restart_pc = restart_q;
  pipe_entry_reg #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .NOP_VAL(NOP_VAL)) u_main (
    .CLK(CLK), .RST_N(RST_N), .load(main_load), .kill(main_kill),
    .in_valid(src_valid), .in_data(src_data), .in_side(src_side), .in_pc(src_pc),
    .in_is_bds(src_is_bds), .in_is_flushed(src_is_flushed),
    .q_valid(out_valid), .q_data(out_data), .q_side(out_side), .q_pc(out_pc),
    .q_is_bds(out_is_bds), .q_is_flushed(out_is_flushed)
  );
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed self-checking bench for pipe_stage.
module tb_pipe_stage;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        in_valid = 1'b0, in_is_bds = 1'b0, flush = 1'b0, out_stall = 1'b0;
  logic [31:0] in_data = '0, in_side = '0, in_pc = '0;
  logic        in_ready, out_valid, out_is_bds, out_is_flushed;
  logic [31:0] out_data, out_side, out_pc, out_restart_pc;
  int          n_vec = 0, n_err = 0;
  always #5 CLK = ~CLK;
  pipe_stage #(.DATA_W(32), .SIDE_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_data(in_data), .in_side(in_side),
    .in_pc(in_pc), .in_is_bds(in_is_bds), .flush(flush), .out_stall(out_stall),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_side(out_side),
    .out_pc(out_pc), .out_restart_pc(out_restart_pc), .out_is_bds(out_is_bds),
    .out_is_flushed(out_is_flushed)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] s, input logic [31:0] pc, input logic bds);
    in_valid  = v;
    in_data   = d;
    in_side   = s;
    in_pc     = pc;
    in_is_bds = bds;
  endtask
  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_side", out_side, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_restart", out_restart_pc, 0);
    chk("rst_bds", out_is_bds, 0);
    chk("rst_flushed", out_is_flushed, 0);
    chk("rst_ready", in_ready, 1);
    #10 RST_N = 1'b1;
    drive(1, 32'h24020005, 32'h104, 32'h100, 0);
    tick;
    chk("cap_valid", out_valid, 1);
    chk("cap_data", out_data, 32'h24020005);
    chk("cap_restart", out_restart_pc, 32'h100);
    chk("cap_side", out_side, 32'h104);
    drive(1, 32'h10000003, 32'h204, 32'h200, 0);
    tick;
    chk("br_restart", out_restart_pc, 32'h200);
    drive(1, 32'h24030007, 32'h208, 32'h204, 1);
    tick;
    chk("bds_pc", out_pc, 32'h204);
    chk("bds_restart", out_restart_pc, 32'h200);
    chk("bds_flag", out_is_bds, 1);
    chk("bds_data", out_data, 32'h24030007);
    drive(1, 32'h2404000a, 32'h208, 32'h208, 0);
    flush = 1'b1;
    tick;
    chk("fl_data", out_data, 32'h0);
    chk("fl_valid", out_valid, 0);
    chk("fl_flushed", out_is_flushed, 1);
    chk("fl_side", out_side, 32'h208);
    chk("fl_pc", out_pc, 32'h208);
    chk("fl_restart", out_restart_pc, 32'h200);
    chk("fl_bds", out_is_bds, 0);
    flush = 1'b0;
    drive(0, 32'hdeadbeef, 32'h210, 32'h20c, 0);
    tick;
    chk("bub_valid", out_valid, 0);
    chk("bub_data", out_data, 32'h0);
    chk("bub_flushed", out_is_flushed, 0);
    chk("bub_side", out_side, 32'h210);
    chk("bub_restart", out_restart_pc, 32'h20c);
    drive(1, 32'h11111111, 32'h304, 32'h300, 0);
    tick;
    chk("a_data", out_data, 32'h11111111);
`ifndef PIPE_STAGE_SKID_EN
    out_stall = 1'b1;
    drive(1, 32'h22222222, 32'h308, 32'h304, 0);
    #1;
    chk("st_ready", in_ready, 0);
    tick;
    chk("st1_data", out_data, 32'h11111111);
    chk("st1_pc", out_pc, 32'h300);
    flush = 1'b1;
    tick;
    chk("st2_valid", out_valid, 1);
    chk("st2_data", out_data, 32'h11111111);
    chk("st2_flushed", out_is_flushed, 0);
    flush = 1'b0;
    tick;
    chk("st3_data", out_data, 32'h11111111);
    chk("st3_restart", out_restart_pc, 32'h300);
    out_stall = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);
    tick;
    chk("rel_data", out_data, 32'h22222222);
    chk("rel_pc", out_pc, 32'h304);
`else
    out_stall = 1'b1;
    drive(1, 32'hbbbb0002, 32'h508, 32'h504, 0);
    #1;
    chk("sk_ready_reg", in_ready, 1);
    tick;
    chk("sk_hold_a", out_data, 32'h11111111);
    chk("sk_ready_lo", in_ready, 0);
    drive(1, 32'hcccc0003, 32'h50c, 32'h508, 0);
    tick;
    chk("sk_hold_a2", out_data, 32'h11111111);
    chk("sk_ready_lo2", in_ready, 0);
    out_stall = 1'b0;
    tick;
    chk("sk_b_data", out_data, 32'hbbbb0002);
    chk("sk_b_restart", out_restart_pc, 32'h504);
    chk("sk_ready_hi", in_ready, 1);
    tick;
    chk("sk_c_data", out_data, 32'hcccc0003);
    chk("sk_c_pc", out_pc, 32'h508);
`endif
    chk("pre_rst_valid", out_valid, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_side", out_side, 32'h0);
    chk("arst_restart", out_restart_pc, 32'h0);
    tick;
    chk("arst_hold", out_valid, 0);
    RST_N = 1'b1;
    drive(1, 32'h33333333, 32'h404, 32'h400, 0);
    tick;
    chk("post_data", out_data, 32'h33333333);
    chk("post_restart", out_restart_pc, 32'h400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32: payload (instruction) width in bits.
REQ-002 Parameter SIDE_W, default 32: side-band width (PC+4 or equivalent), never cleared by flush.
REQ-003 Parameter NOP_VAL, default all-zero of DATA_W: payload driven forward for bubbles and flushes.
REQ-004 Clock and reset: one clock, CLK; reset is asynchronous and active-low, RST_N.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  upstream holds a real instruction.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_side  in  SIDE_W  upstream side-band.
REQ-010 in_pc  in  32  upstream instruction PC.
REQ-011 in_is_bds  in  1  upstream instruction is a branch delay slot.
REQ-012 flush  in  1  kill the entry being captured this cycle.
REQ-013 out_stall  in  1  downstream stage stalled; hold outputs.
REQ-014 in_ready  out  1  stage accepts the upstream entry this cycle.
REQ-015 out_valid, out_data, out_side, out_pc  out  1/DATA_W/SIDE_W/32  registered entry.
REQ-016 out_restart_pc  out  32  PC for exception restart.
REQ-017 out_is_bds, out_is_flushed  out  1/1  delay-slot flag; entry was flushed (masks interrupt detection).

Function
REQ-018 Capture on CLK rise when in_ready=1; otherwise every output holds its value.
REQ-019 Capture latency is exactly 1 cycle, input to output.
REQ-020 in_valid=0 at capture: out_valid=0, out_data=NOP_VAL, out_is_flushed=0; side-band, pc and flags still load.
REQ-021 flush=1 at capture: out_valid=0, out_data=NOP_VAL, out_is_flushed=1; out_side, out_pc load normally.
REQ-022 flush has priority over in_valid; out_stall has priority over flush: a stalled stage ignores flush.
REQ-023 out_restart_pc loads in_pc only on a capture with in_is_bds=0 and flush=0; otherwise it holds, so a delay slot reports its branch's PC.
REQ-024 out_is_bds loads in_is_bds on every capture, including flushed captures.
REQ-025 Without the skid option, in_ready = ~out_stall, purely combinational.

Reset
REQ-026 While RST_N=0, asynchronously: out_valid=0, out_data=NOP_VAL, out_side=0, out_pc=0, out_restart_pc=0, out_is_bds=0, out_is_flushed=0.
REQ-027 With the skid option, reset also empties the skid entry; a reset during a stall discards both entries.
REQ-028 The first capture is the first CLK rise after RST_N deasserts.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN: when defined, the block SHALL add one skid entry, and in_ready SHALL be a register output with no combinational path from out_stall.
REQ-030 Skid states: EMPTY (main entry only) and FULL (skid entry occupied); in_ready = (state==EMPTY).
REQ-031 EMPTY with out_stall=1 and an upstream entry presented: the entry goes to skid; state goes to FULL; the main entry holds.
REQ-032 FULL with out_stall=0: skid moves to main and state goes to EMPTY; no new capture that cycle.
REQ-033 flush=1 while FULL kills the skid entry (NOP_VAL, is_flushed=1); restart-PC rules apply when the skid entry is promoted.
REQ-034 Without the macro, no skid storage and no state register is present; behaviour is exactly REQ-018..REQ-025.

Structure
REQ-035 Shared package pipe_pkg: parameter defaults, skid state enum, and a packed entry struct holding valid, data, side, pc, is_bds and is_flushed.
REQ-036 One sub-module, pipe_entry_reg, is the natural split: a single loadable entry with kill; instantiated once, or twice with the skid option.

Verification
REQ-037 Reset mid-stream: RST_N low for 1 cycle while out_valid=1, then released -> all outputs zero / NOP_VAL immediately, not at a clock edge.
REQ-038 in_data=0x24020005, in_pc=0x100, valid -> next cycle out_data=0x24020005, out_restart_pc=0x100, out_valid=1.
REQ-039 Branch at pc 0x200, then delay slot at pc 0x204 with in_is_bds=1 -> out_pc=0x204, out_restart_pc=0x200, out_is_bds=1.
REQ-040 flush=1 with in_side=0x208 -> out_data=NOP_VAL, out_valid=0, out_is_flushed=1, out_side=0x208.
REQ-041 out_stall=1 for 3 cycles plus flush=1 in cycle 2 -> outputs unchanged through all 3 cycles; no entry lost.
REQ-042 Skid option: out_stall rises while in_valid=1 -> in_ready=0 next cycle; after release, entries appear in order A then B with no duplicate.
